pc_scheduler: RTL and testbench

//  Multi-program PC unit with round-robin time slicing. Holds the fetch PC and a per-slot context table.

---
 rtl/pc_scheduler_pkg.sv | 20 ++
 rtl/pc_scheduler_if.sv | 41 ++++
 rtl/pc_scheduler_context_table.sv | 41 ++++
 rtl/pc_scheduler.sv | 144 ++++++++++++++
 tb/tb_pc_scheduler.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pc_scheduler_pkg.sv
// Shared definitions for the PC scheduler slice.
//   BR_*       : branch-operation codes decoded by the next-pc mux
//   slot_base  : start address of a slot's address region (slot * region)
package pc_scheduler_pkg;

    localparam logic [2:0] BR_NEXT  = 3'b000;  // pc+1
    localparam logic [2:0] BR_JUMP  = 3'b001;  // B+target
    localparam logic [2:0] BR_ZERO  = 3'b010;  // zero ? B+target : pc+1
    localparam logic [2:0] BR_REG   = 3'b011;  // absolute register target
    localparam logic [2:0] BR_NZERO = 3'b100;  // zero ? pc+1 : B+target
    localparam logic [2:0] BR_NEG   = 3'b101;  // negative ? B+target : pc+1
    localparam logic [2:0] BR_LE    = 3'b110;  // (negative|zero) ? B+target : pc+1
    localparam logic [2:0] BR_HOLD  = 3'b111;  // hold pc

    // Computed in 64 bits; callers truncate to the address width (modulo 2^AW).
    function automatic logic [63:0] slot_base(input int unsigned slot, input int unsigned region);
        return 64'(slot) * 64'(region);
    endfunction

endpackage

// File: rtl/pc_scheduler_if.sv
// Control-unit <-> PC scheduler bus.
//   master : control unit (drives stall, dispatch, branch and flag inputs; sees pc/status)
//   slave  : pc_scheduler
// Signals: stop, load_pc, load_slot, load_resume, load_addr, end_program, branch_op,
//          branch_target, branch_reg, zero, negative (to scheduler); pc, active_slot,
//          saved_pc, saved_slot, switch_pulse, fault (from scheduler).
interface pc_scheduler_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned SW = 2
);
    logic          stop;
    logic          load_pc;
    logic [SW-1:0] load_slot;
    logic          load_resume;
    logic [AW-1:0] load_addr;
    logic          end_program;
    logic [2:0]    branch_op;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] branch_reg;
    logic          zero;
    logic          negative;
    logic [AW-1:0] pc;
    logic [SW-1:0] active_slot;
    logic [AW-1:0] saved_pc;
    logic [SW-1:0] saved_slot;
    logic          switch_pulse;
    logic          fault;

    modport master (
        output stop, load_pc, load_slot, load_resume, load_addr, end_program,
               branch_op, branch_target, branch_reg, zero, negative,
        input  pc, active_slot, saved_pc, saved_slot, switch_pulse, fault
    );

    modport slave (
        input  stop, load_pc, load_slot, load_resume, load_addr, end_program,
               branch_op, branch_target, branch_reg, zero, negative,
        output pc, active_slot, saved_pc, saved_slot, switch_pulse, fault
    );

endinterface

// File: rtl/pc_scheduler_context_table.sv
// Per-slot saved-PC table.
//   clock, reset : clock and synchronous active-low reset (reset loads base(s) into entry s)
//   we, wr_slot, wr_data : one synchronous write port
//   rd_slot, rd_data     : one asynchronous read port (reads 0 for an out-of-range slot)
module pc_scheduler_context_table
    import pc_scheduler_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned NSLOTS = 4,
    parameter int unsigned REGION = 1000,
    parameter int unsigned SW     = $clog2(NSLOTS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [SW-1:0] wr_slot,
    input  logic [AW-1:0] wr_data,
    input  logic [SW-1:0] rd_slot,
    output logic [AW-1:0] rd_data
);

    logic [AW-1:0] ctx_q [NSLOTS];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < int'(NSLOTS); s++) begin
                ctx_q[s] <= AW'(slot_base(s, REGION));
            end
        end else if (we && (32'(wr_slot) < NSLOTS)) begin
            ctx_q[wr_slot] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_slot) < NSLOTS) begin
            rd_data = ctx_q[rd_slot];
        end
    end

endmodule

// File: rtl/pc_scheduler.sv
// Multi-program PC unit with round-robin time slicing.
// Slot 0 is the OS/dispatcher; user slots 1..NSLOTS-1 each own the region
// [s*REGION, s*REGION+REGION-1]. A user program is forced back to the OS when its
// quantum expires or when it signals end_program.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   bus (slave)  : control-unit inputs (stall, dispatch, branch, flags) and pc/status outputs
// Optional feature: define PCU_BOUNDS_CHECK_EN to turn an out-of-region next pc in a
// user slot into a switch with a one-cycle fault pulse; otherwise fault stays 0.
module pc_scheduler
    import pc_scheduler_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned NSLOTS   = 4,
    parameter int unsigned QUANTUM  = 5,
    parameter int unsigned REGION   = 1000,
    parameter int unsigned OS_ENTRY = 0,
    parameter int unsigned RESET_PC = 0
) (
    input logic           clock,
    input logic           reset,
    pc_scheduler_if.slave bus
);

    localparam int unsigned SW = $clog2(NSLOTS);
    localparam int unsigned CW = $clog2(QUANTUM + 1);
    localparam logic [CW-1:0] QUANTUM_CNT = CW'(QUANTUM);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] saved_pc_q;
    logic [SW-1:0] slot_q;
    logic [SW-1:0] saved_slot_q;
    logic [CW-1:0] count_q;
    logic          switch_q;
    logic          fault_q;

    logic [AW-1:0] base_act;
    logic [AW-1:0] base_load;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] br_tgt;
    logic [AW-1:0] br_pc;
    logic [AW-1:0] ctx_rdata;
    logic          user_slot;
    logic          quantum_hit;
    logic          load_ok;
    logic          bounds_fault;
    logic          do_switch;
    logic          ctx_we;

    always_comb begin
        base_act    = AW'(slot_base(32'(slot_q), REGION));
        base_load   = AW'(slot_base(32'(bus.load_slot), REGION));
        pc_inc      = pc_q + AW'(1);
        br_tgt      = base_act + bus.branch_target;
        user_slot   = (slot_q != '0);
        quantum_hit = user_slot && (count_q == QUANTUM_CNT);
        load_ok     = (32'(bus.load_slot) < NSLOTS);

        case (bus.branch_op)
            BR_NEXT:  br_pc = pc_inc;
            BR_JUMP:  br_pc = br_tgt;
            BR_ZERO:  br_pc = bus.zero ? br_tgt : pc_inc;
            BR_REG:   br_pc = bus.branch_reg;
            BR_NZERO: br_pc = bus.zero ? pc_inc : br_tgt;
            BR_NEG:   br_pc = bus.negative ? br_tgt : pc_inc;
            BR_LE:    br_pc = (bus.negative || bus.zero) ? br_tgt : pc_inc;
            default:  br_pc = pc_q;  // BR_HOLD
        endcase

`ifdef PCU_BOUNDS_CHECK_EN
        // Only the branch path produces a next pc to check; a dispatch overrides it.
        bounds_fault = user_slot && !bus.load_pc &&
                       ((br_pc < base_act) || (br_pc > base_act + AW'(REGION - 1)));
`else
        bounds_fault = 1'b0;
`endif

        do_switch = quantum_hit || bus.end_program || bounds_fault;
        // The OS slot has no context to save.
        ctx_we    = !bus.stop && do_switch && user_slot;
    end

    pc_scheduler_context_table #(
        .AW     (AW),
        .NSLOTS (NSLOTS),
        .REGION (REGION),
        .SW     (SW)
    ) u_ctx (
        .clock   (clock),
        .reset   (reset),
        .we      (ctx_we),
        .wr_slot (slot_q),
        .wr_data (pc_q),
        .rd_slot (bus.load_slot),
        .rd_data (ctx_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q         <= AW'(RESET_PC);
            slot_q       <= '0;
            count_q      <= '0;
            saved_pc_q   <= '0;
            saved_slot_q <= '0;
            switch_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else if (bus.stop) begin
            switch_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            switch_q <= do_switch;
            fault_q  <= bounds_fault;
            if (do_switch) begin
                if (user_slot) begin
                    saved_pc_q   <= pc_q;
                    saved_slot_q <= slot_q;
                end
                pc_q    <= AW'(OS_ENTRY);
                slot_q  <= '0;
                count_q <= '0;
            end else if (bus.load_pc) begin
                if (load_ok) begin
                    slot_q  <= bus.load_slot;
                    count_q <= '0;
                    pc_q    <= bus.load_resume ? ctx_rdata : base_load + bus.load_addr;
                end else begin
                    pc_q <= pc_inc;
                end
            end else begin
                pc_q <= br_pc;
                if (user_slot && (count_q != QUANTUM_CNT)) begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    assign bus.pc           = pc_q;
    assign bus.active_slot  = slot_q;
    assign bus.saved_pc     = saved_pc_q;
    assign bus.saved_slot   = saved_slot_q;
    assign bus.switch_pulse = switch_q;
    assign bus.fault        = fault_q;

endmodule

// File: tb/tb_pc_scheduler.sv
// Directed bench for pc_scheduler (NSLOTS=4, QUANTUM=5, REGION=1000).
// Each step drives inputs, queues the state expected after the next edge, then
// pops and compares it #1 after that edge.
module tb_pc_scheduler;

    logic clock;
    logic reset;

    pc_scheduler_if #(.AW(32), .SW(2)) bus ();

    pc_scheduler #(
        .AW       (32),
        .NSLOTS   (4),
        .QUANTUM  (5),
        .REGION   (1000),
        .OS_ENTRY (0),
        .RESET_PC (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef PCU_BOUNDS_CHECK_EN
    localparam logic [31:0] REG_TGT = 32'd2042;
`else
    localparam logic [31:0] REG_TGT = 32'd42;
`endif

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [1:0]  slot;
        logic [31:0] spc;
        logic [1:0]  ssl;
        logic        sw;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stop          = 1'b0;
        bus.load_pc       = 1'b0;
        bus.load_slot     = '0;
        bus.load_resume   = 1'b0;
        bus.load_addr     = '0;
        bus.end_program   = 1'b0;
        bus.branch_op     = 3'b000;
        bus.branch_target = '0;
        bus.branch_reg    = '0;
        bus.zero          = 1'b0;
        bus.negative      = 1'b0;
    endtask

    task automatic load(input logic [1:0] slot, input logic resume, input logic [31:0] addr);
        bus.load_pc     = 1'b1;
        bus.load_slot   = slot;
        bus.load_resume = resume;
        bus.load_addr   = addr;
    endtask

    task automatic br(input logic [2:0] op, input logic [31:0] tgt, input logic z,
                      input logic n);
        bus.branch_op     = op;
        bus.branch_target = tgt;
        bus.zero          = z;
        bus.negative      = n;
    endtask

    task automatic step(input string tag, input logic [31:0] e_pc, input logic [1:0] e_slot,
                        input logic [31:0] e_spc, input logic [1:0] e_ssl, input logic e_sw,
                        input logic e_flt);
        exp_t e;
        exp_t got;
        e.tag = tag; e.pc = e_pc; e.slot = e_slot; e.spc = e_spc;
        e.ssl = e_ssl; e.sw = e_sw; e.flt = e_flt;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            got = exp_q.pop_front();
            chk({got.tag, ".pc"},           bus.pc,                   got.pc);
            chk({got.tag, ".active_slot"},  32'(bus.active_slot),     32'(got.slot));
            chk({got.tag, ".saved_pc"},     bus.saved_pc,             got.spc);
            chk({got.tag, ".saved_slot"},   32'(bus.saved_slot),      32'(got.ssl));
            chk({got.tag, ".switch_pulse"}, 32'(bus.switch_pulse),    32'(got.sw));
            chk({got.tag, ".fault"},        32'(bus.fault),           32'(got.flt));
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        step("reset0", 0, 0, 0, 0, 0, 0);
        step("reset1", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step("os_inc", 1, 0, 0, 0, 0, 0);

        // T2: fresh dispatch into slot 1, run out the quantum
        load(2'd1, 1'b0, 32'd0);
        step("t2_disp", 1000, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step("t2_run", 32'(1000 + i), 1, 0, 0, 0, 0);
        step("t2_preempt", 0, 0, 1005, 1, 1, 0);
        step("t2_os", 1, 0, 1005, 1, 0, 0);

        // T3: resume slot 1 from its saved context
        load(2'd1, 1'b1, 32'd0);
        step("t3_resume", 1005, 1, 1005, 1, 0, 0);
        for (int i = 1; i <= 5; i++) step("t3_run", 32'(1005 + i), 1, 1005, 1, 0, 0);

        // T5: stall at count==QUANTUM holds everything, then end_program beats load_pc
        bus.stop = 1'b1;
        step("t5_stop0", 1010, 1, 1005, 1, 0, 0);
        bus.stop = 1'b1;
        step("t5_stop1", 1010, 1, 1005, 1, 0, 0);
        bus.end_program = 1'b1;
        load(2'd3, 1'b0, 32'd0);
        step("t5_end_vs_load", 0, 0, 1010, 1, 1, 0);

        // T4: conditional branches in slot 2
        load(2'd2, 1'b0, 32'd3);
        step("t4_disp", 2003, 2, 1010, 1, 0, 0);
        br(3'b010, 32'd7, 1'b1, 1'b0);
        step("t4_bz_taken", 2007, 2, 1010, 1, 0, 0);
        br(3'b010, 32'd7, 1'b0, 1'b0);
        step("t4_bz_fall", 2008, 2, 1010, 1, 0, 0);
        br(3'b100, 32'd7, 1'b0, 1'b0);
        step("t4_bnz_taken", 2007, 2, 1010, 1, 0, 0);
        br(3'b101, 32'd20, 1'b0, 1'b1);
        step("t4_bneg_taken", 2020, 2, 1010, 1, 0, 0);
        br(3'b011, 32'd0, 1'b0, 1'b0);
        bus.branch_reg = REG_TGT;
        step("t4_breg", REG_TGT, 2, 1010, 1, 0, 0);
        bus.end_program = 1'b1;
        step("t4_end", 0, 0, REG_TGT, 2, 1, 0);

        // T1: reset mid-run restores the context table
        load(2'd3, 1'b0, 32'd9);
        step("t1_disp", 3009, 3, REG_TGT, 2, 0, 0);
        reset = 1'b0;
        step("t1_reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        load(2'd2, 1'b1, 32'd0);
        step("t1_ctx2", 2000, 2, 0, 0, 0, 0);
        bus.end_program = 1'b1;
        step("t1_end", 0, 0, 2000, 2, 1, 0);
        step("os_step", 1, 0, 2000, 2, 0, 0);
        bus.end_program = 1'b1;
        step("os_end", 0, 0, 2000, 2, 1, 0);

        // Remaining branch codes in slot 3, then quantum preemption
        load(2'd3, 1'b0, 32'd0);
        step("s3_disp", 3000, 3, 2000, 2, 0, 0);
        br(3'b001, 32'd10, 1'b0, 1'b0);
        step("s3_jump", 3010, 3, 2000, 2, 0, 0);
        br(3'b110, 32'd4, 1'b1, 1'b0);
        step("s3_ble_zero", 3004, 3, 2000, 2, 0, 0);
        br(3'b111, 32'd0, 1'b0, 1'b0);
        step("s3_hold", 3004, 3, 2000, 2, 0, 0);
        br(3'b110, 32'd4, 1'b0, 1'b0);
        step("s3_ble_fall", 3005, 3, 2000, 2, 0, 0);
        br(3'b110, 32'd4, 1'b0, 1'b1);
        step("s3_ble_neg", 3004, 3, 2000, 2, 0, 0);
        step("s3_preempt", 0, 0, 3004, 3, 1, 0);

`ifdef PCU_BOUNDS_CHECK_EN
        // T6: out-of-region jump faults and saves the current pc
        load(2'd1, 1'b0, 32'd0);
        step("t6_disp", 1000, 1, 3004, 3, 0, 0);
        br(3'b001, 32'd1500, 1'b0, 1'b0);
        step("t6_fault", 0, 0, 1000, 1, 1, 1);
        step("t6_after", 1, 0, 1000, 1, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
